// File: rtl/keypad_num_entry.sv
// keypad_num_entry: 4x4 active-low keypad scanner with sweep debounce
// and 4-digit decimal entry (digits, backspace, clear, enter).
module keypad_num_entry #(
  parameter int unsigned SIZE = 16,
  parameter logic [31:0] DIV  = 32'd100_000,
  parameter int unsigned DEB  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      row,
  output logic [3:0]      col,
  output logic [SIZE-1:0] entry,
  output logic [SIZE-1:0] num,
  output logic            valid,
  output logic            key_pulse,
  output logic [3:0]      key_code
);

  localparam int unsigned DW = (DEB > 1) ? $clog2(DEB) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DEB - 1);
  localparam int unsigned XW = SIZE + 4;
  localparam logic [XW-1:0] TEN_X = XW'(10);
  localparam logic [XW-1:0] MAX_X = XW'(9999);
  localparam logic [SIZE-1:0] TEN_S = SIZE'(10);

  typedef enum logic {RELEASED, HELD} state_t;

  logic [31:0]     cnt;
  logic [1:0]      idx;
  logic            tick;
  logic [15:0]     snap;
  logic [15:0]     snap_nx;
  logic [15:0]     prev;
  logic [15:0]     stable;
  logic [DW-1:0]   deb;
  logic            upd;
  logic [4:0]      ones;
  logic [3:0]      pos;
  logic [3:0]      code;
  logic [XW-1:0]   ent_x;
  state_t          state_q;
  state_t          state_d;
  logic [SIZE-1:0] entry_d;
  logic [SIZE-1:0] num_d;
  logic            valid_d;
  logic            pulse_d;
  logic [3:0]      code_d;

  // Snapshot bit {c,r} set when row r reads closed on column c.
  function automatic logic [3:0] key_map(input logic [3:0] p);
    logic [3:0] k;
    case (p)
      4'h0: k = 4'h1;
      4'h1: k = 4'h4;
      4'h2: k = 4'h7;
      4'h3: k = 4'hE;
      4'h4: k = 4'h2;
      4'h5: k = 4'h5;
      4'h6: k = 4'h8;
      4'h7: k = 4'h0;
      4'h8: k = 4'h3;
      4'h9: k = 4'h6;
      4'hA: k = 4'h9;
      4'hB: k = 4'hF;
      4'hC: k = 4'hA;
      4'hD: k = 4'hB;
      4'hE: k = 4'hC;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  assign tick = (cnt == DIV - 32'd1);
  assign col  = ~(4'b0001 << idx);

  // Merge the current column's rows into the sweep snapshot.
  always_comb begin
    snap_nx = snap;
    for (int r = 0; r < 4; r++) begin
      snap_nx[{idx, 2'(r)}] = ~row[r];
    end
  end

  // Dwell counter, column rotation and snapshot capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      idx  <= '0;
      snap <= '0;
    end else if (tick) begin
      cnt  <= '0;
      idx  <= idx + 2'd1;
      snap <= snap_nx;
    end else begin
      cnt  <= cnt + 32'd1;
    end
  end

  // Sweep-to-sweep debounce feeding the stable key map.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev   <= '0;
      stable <= '0;
      deb    <= '0;
      upd    <= 1'b0;
    end else begin
      upd <= 1'b0;
      if (tick && idx == 2'd3) begin
        prev <= snap_nx;
        if (snap_nx == prev) begin
          if (deb != DMAX) deb <= deb + DW'(1);
          if (deb >= DMAX) begin
            stable <= snap_nx;
            upd    <= 1'b1;
          end
        end else begin
          deb <= '0;
        end
      end
    end
  end

  // Count closed keys and remember the last one seen.
  always_comb begin
    ones = '0;
    pos  = '0;
    for (int i = 0; i < 16; i++) begin
      if (stable[i]) begin
        ones = ones + 5'd1;
        pos  = 4'(i);
      end
    end
  end

  assign code = key_map(pos);

  // Press/release FSM and key actions on entry/num.
  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
    valid_d = 1'b0;
    code_d  = key_code;
    entry_d = entry;
    num_d   = num;
    ent_x   = XW'(entry) * TEN_X + XW'(code);
    unique case (state_q)
      RELEASED: begin
        if (upd && ones == 5'd1) begin
          state_d = HELD;
          pulse_d = 1'b1;
          code_d  = code;
          unique case (1'b1)
            (code <= 4'd9): begin
              if (ent_x <= MAX_X) entry_d = ent_x[SIZE-1:0];
            end
            (code == 4'hE): entry_d = entry / TEN_S;
            (code == 4'hF): begin
              num_d   = entry;
              valid_d = 1'b1;
              entry_d = '0;
            end
            default: entry_d = '0;
          endcase
        end
      end
      HELD: begin
        if (upd && stable == '0) state_d = RELEASED;
      end
      default: state_d = RELEASED;
    endcase
  end

  // Register FSM state and all visible outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RELEASED;
      entry     <= '0;
      num       <= '0;
      valid     <= 1'b0;
      key_pulse <= 1'b0;
      key_code  <= '0;
    end else begin
      state_q   <= state_d;
      entry     <= entry_d;
      num       <= num_d;
      valid     <= valid_d;
      key_pulse <= pulse_d;
      key_code  <= code_d;
    end
  end

endmodule

// File: doc/keypad_num_entry.md
Name: keypad_num_entry

Overview:
- Scans a 4x4 active-low matrix keypad and debounces it.
- Decodes single key presses and assembles a decimal number of up to 4 digits, with backspace, clear and enter.
- It is the input-side counterpart of the 7-segment number display driver. The live entry value and the committed value both feed that driver's num input.

Parameters:
SIZE, 16, width of entry/num outputs; must be >= 14 to hold 9999
DIV, 32'd100_000, clk cycles each column stays driven (scan dwell)
DEB, 4, consecutive identical full sweeps required before a snapshot is taken as stable (>= 1)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
row  input  4  keypad rows, active-low (pulled up; 0 = key closed on the driven column)
col  output  4  keypad columns, one-hot active-low drive
entry  output  SIZE  number currently being typed (0..9999)
num  output  SIZE  last committed number
valid  output  1  one-cycle pulse when num is updated by enter
key_pulse  output  1  one-cycle pulse per accepted key press
key_code  output  4  code of the last accepted key (held until the next accepted key)

Behaviour:
- Reset (rst_n low at posedge):
  - col=4'b1110, entry=0, num=0, valid=0, key_pulse=0, key_code=0.
  - Dwell counter=0, column index=0, debounce count=0.
  - Stable snapshot = all released; FSM in RELEASED.
  - Reset mid-scan or mid-entry discards everything.
- Scan:
  - 32-bit dwell counter runs 0..DIV-1 and wraps.
  - At cnt==DIV-1: row is sampled into the 4 snapshot bits of the current column, and the column index advances (3 wraps to 0).
  - col[i]=0 iff index==i.
  - One sweep = 4*DIV cycles. A sweep completes on the tick that samples column 3.
- Key map, position (row r, col c) -> code:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E(*),0,F(#),D
- Debounce:
  - At sweep completion, compare the new 16-bit snapshot with the previous sweep.
  - Equal: debounce count increments, saturating at DEB-1. Different: count resets to 0.
  - When the snapshot is equal and the count (before increment) is >= DEB-1, or when DEB==1, the snapshot is copied to the stable register.
  - A glitch shorter than DEB sweeps never reaches the stable register.
- FSM, evaluated on the cycle after the stable register updates:
  - RELEASED + stable has exactly one key closed → register key_pulse=1 and key_code, apply the key action, go to HELD.
  - RELEASED + zero keys or more than one key → stay; no event.
  - HELD + stable all released → RELEASED.
  - HELD + anything else → stay; no event. A held key therefore yields exactly one pulse.
- Key actions (registered on the same edge as key_pulse):
  - digit d: if entry <= 999 then entry = entry*10 + d, computed in a >= SIZE+4-bit intermediate; otherwise entry unchanged. key_pulse still asserts.
  - 0xE (*): entry = entry/10 (0 stays 0).
  - 0xA–0xD: entry = 0; num unchanged.
  - 0xF (#): num = entry, valid=1 for one cycle, entry = 0.
  - Enter with entry 0 still commits 0 and pulses valid.
- valid and key_pulse are deasserted on all other cycles.

Test Plan:
- Common bench settings: DIV=4, DEB=2, so a sweep is 16 cycles. A key is held ≥ 4 sweeps, and released ≥ 4 sweeps between presses.
- Reset: assert rst_n=0 for 2 cycles with rows idle (4'hF) -> col=1110, entry=0, num=0, valid=0, key_pulse=0. col rotates 1110→1101→1011→0111 every 4 cycles.
- Entry/commit: press 1,2,3,4, then # -> entry reads 1, 12, 123, 1234. On #: num=1234, valid high exactly 1 cycle, entry=0, key_code=0xF.
- Overflow: with entry=1234, press 5 -> key_pulse=1 and key_code=5, entry stays 1234.
- Backspace/clear: entry=1234 then * -> 123, * -> 12. Press A -> entry=0, num unchanged. * at 0 -> entry stays 0.
- Bounce and multi-key:
  - Key 7 closed for 1 sweep only -> no key_pulse.
  - Keys 1 and 5 closed together for 4 sweeps -> no key_pulse, entry unchanged.
  - Key 8 held 20 sweeps -> exactly one key_pulse, entry gains one digit.
- Reset mid-operation: entry=56 and key 9 held, pulse rst_n=0 -> all outputs return to reset values. Key 9 still held after reset produces one press once stable for DEB sweeps: entry=9.
